// File: rtl/pc_seq_pkg.sv
// Shared types and width helpers for the PC sequencer and its return-address stack.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_HOLD,
    SRC_BRANCH,
    SRC_JUMP,
    SRC_CALL,
    SRC_RET,
    SRC_SWAP
  } pc_src_e;

  function automatic int ras_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int ras_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack: push on call, pop on return, in-place top replace on swap.
module return_addr_stack
  import pc_seq_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             underflow_o
);

  localparam int PW = ras_ptr_w(RAS_DEPTH);
  localparam int CW = ras_cnt_w(RAS_DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d, top_idx, wr_idx;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             unf_q, unf_d, wr_en;

  // ptr_q is the next free slot; once full it also addresses the oldest entry
  assign top_idx     = ptr_q - PW'(1);
  assign top_o       = mem_q[top_idx];
  assign empty_o     = (cnt_q == '0);
  assign full_o      = (cnt_q == CNT_MAX);
  assign underflow_o = unf_q;

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    unf_d  = unf_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (pop_i && empty_o) unf_d = 1'b1;
    if (push_i && pop_i && !empty_o) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push_i) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + PW'(1);
      if (!full_o) cnt_d = cnt_q + CW'(1);
    end else if (pop_i && !empty_o) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      unf_q <= unf_d;
    end
  end

  // Storage is data only; its contents are meaningless while count is zero.
  always_ff @(posedge Clk) begin
    if (wr_en) mem_q[wr_idx] <= data_i;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with prioritised next-PC selection and a return-address stack.
// Optional target alignment check enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               INC          = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic             Jump,
  input  logic             Call,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic             Return,
  output logic [WIDTH-1:0] PCResult,
  output logic [WIDTH-1:0] PCPlus,
  output logic             RasEmpty,
  output logic             RasFull,
  output logic             RasUnderflow,
  output logic             Misaligned
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  logic [WIDTH-1:0] pc_q, pc_d, target, ras_top;
  logic             ras_empty;
  pc_src_e          src;

  assign PCResult = pc_q;
  assign PCPlus   = pc_q + INC_W;
  assign RasEmpty = ras_empty;

  return_addr_stack #(
    .WIDTH    (WIDTH),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .Clk        (Clk),
    .Reset      (Reset),
    .push_i     (Call),
    .pop_i      (Return),
    .data_i     (PCPlus),
    .top_o      (ras_top),
    .empty_o    (ras_empty),
    .full_o     (RasFull),
    .underflow_o(RasUnderflow)
  );

  always_comb begin
    src = SRC_SEQ;
    if (Return && Call) src = SRC_SWAP;
    else if (Return)    src = SRC_RET;
    else if (Call)      src = SRC_CALL;
    else if (Jump)      src = SRC_JUMP;
    else if (BranchTaken) src = SRC_BRANCH;
    else if (Stall)     src = SRC_HOLD;
  end

  // A return with nothing on the stack falls through to the sequential address.
  always_comb begin
    case (src)
      SRC_RET, SRC_SWAP:  target = ras_empty ? PCPlus : ras_top;
      SRC_CALL, SRC_JUMP: target = JumpTarget;
      SRC_BRANCH:         target = BranchTarget;
      SRC_HOLD:           target = pc_q;
      default:            target = PCPlus;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [WIDTH-1:0] LOW_MASK = INC_W - WIDTH'(1);

  logic chk_en, mis_d, mis_q;

  always_comb begin
    chk_en = (src inside {SRC_BRANCH, SRC_JUMP, SRC_CALL}) ||
             ((src inside {SRC_RET, SRC_SWAP}) && !ras_empty);
    mis_d  = chk_en && ((target & LOW_MASK) != '0);
    pc_d   = chk_en ? (target & ~LOW_MASK) : target;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) mis_q <= 1'b0;
    else       mis_q <= mis_d;
  end

  assign Misaligned = mis_q;
`else
  assign pc_d       = target;
  assign Misaligned = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) pc_q <= RESET_VECTOR;
    else       pc_q <= pc_d;
  end

endmodule
